// File: rtl/adder_pkg.sv
// Shared definitions for the plain integer adder used by the core.
// XLEN   : native word width, used as the adder's default operand width.
// word_t : a native machine word.
package adder_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

endpackage : adder_pkg

// File: rtl/cla4.sv
// 4-bit carry-lookahead slice.
// a, b : 4-bit operand nibbles
// cin  : carry into bit 0
// sum  : 4-bit sum
// cout : carry out of bit 3
// G, P : group generate / propagate for this nibble
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       G,
    output logic       P
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:1] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every internal carry is a flat sum of products of g/p/cin, so no
    // carry ripples inside the slice.
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    assign P = &p;

    assign cout = G | (P & cin);
    assign sum  = p ^ {c[3:1], cin};

endmodule : cla4

// File: rtl/adder_32.sv
// Registered WIDTH-bit adder: y/cout hold (a + b) one clock after sampling.
// clk   : rising-edge clock
// reset : asynchronous active-high clear of y/cout
// a, b  : operands (unsigned or two's complement, same bits either way)
// y     : registered sum mod 2^WIDTH
// cout  : registered carry out of the MSB (unsigned overflow)
module adder_32
    import adder_pkg::*;
#(
    parameter int WIDTH = XLEN  // must be a multiple of 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             cout
);

    localparam int NSLICE = WIDTH / 4;

    logic [NSLICE:0]   c;
    logic [NSLICE-1:0] grp_g;
    logic [NSLICE-1:0] grp_p;
    logic [WIDTH-1:0]  y_d;
    logic              cout_d;
    logic [WIDTH-1:0]  y_q;
    logic              cout_q;

    assign c[0] = 1'b0;

    // Slice carries ripple nibble to nibble; this chain is the critical path.
    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        cla4 u_cla4 (
            .a    (a[4*i +: 4]),
            .b    (b[4*i +: 4]),
            .cin  (c[i]),
            .sum  (y_d[4*i +: 4]),
            .cout (c[i+1]),
            .G    (grp_g[i]),
            .P    (grp_p[i])
        );
    end

    assign cout_d = c[NSLICE];

    // Group G/P are left available for a second-level lookahead should the
    // ripple ever fail timing; nothing consumes them today.
    logic unused_grp;
    assign unused_grp = ^{grp_g, grp_p};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            cout_q <= cout_d;
        end
    end

    assign y    = y_q;
    assign cout = cout_q;

endmodule : adder_32

// File: tb/tb_adder_32.sv
module tb_adder_32;
    import adder_pkg::*;

    typedef struct {
        word_t a;
        word_t b;
        word_t y;
        logic  co;
    } vec_t;

    logic  clk = 1'b0;
    logic  reset;
    word_t a, b, y;
    logic  cout;

    int checks = 0;
    int errors = 0;

    adder_32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .y     (y),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: 33-bit integer sum, split into wrapped word and carry.
    task automatic ref_sum(input word_t x, input word_t z, output word_t s, output logic co);
        logic [32:0] t;
        t  = {1'b0, x} + {1'b0, z};
        s  = t[31:0];
        co = t[32];
    endtask

    vec_t  tbl[9];
    word_t qy[$];
    logic  qc[$];

    initial begin
        word_t es;
        logic  ec;

        tbl[0] = '{32'd0,          32'd0,          32'd0,          1'b0};
        tbl[1] = '{32'd169,        32'd21,         32'd190,        1'b0};
        tbl[2] = '{32'd11,         32'd42,         32'd53,         1'b0};
        tbl[3] = '{32'd9,          32'd31,         32'd40,         1'b0};
        tbl[4] = '{32'd7,          32'd1250,       32'd1257,       1'b0};
        tbl[5] = '{32'h0000_000F,  32'h0000_0001,  32'h0000_0010,  1'b0};
        tbl[6] = '{32'hFFFF_FFFF,  32'h0000_0001,  32'h0000_0000,  1'b1};
        tbl[7] = '{32'h8000_0000,  32'h8000_0000,  32'h0000_0000,  1'b1};
        tbl[8] = '{32'h7FFF_FFFF,  32'h0000_0001,  32'h8000_0000,  1'b0};

        // Reset held with live operands: outputs stay cleared.
        reset = 1'b1;
        a = 32'd5;
        b = 32'd7;
        repeat (2) @(negedge clk);
        chk("reset_y", {1'b0, y}, 33'd0);
        chk("reset_cout", {32'd0, cout}, 33'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_y", {1'b0, y}, 33'd12);
        chk("post_reset_cout", {32'd0, cout}, 33'd0);

        // Directed table.
        foreach (tbl[i]) begin
            a = tbl[i].a;
            b = tbl[i].b;
            @(negedge clk);
            chk($sformatf("tbl%0d_y", i), {1'b0, y}, {1'b0, tbl[i].y});
            chk($sformatf("tbl%0d_cout", i), {32'd0, cout}, {32'd0, tbl[i].co});
        end

        // Asynchronous reset between edges discards the held result.
        a = 32'hFFFF_FFF0;
        b = 32'h0000_0123;
        @(negedge clk);
        chk("pre_async_y", {1'b0, y}, 33'h0_0000_0113);
        chk("pre_async_cout", {32'd0, cout}, 33'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_y", {1'b0, y}, 33'd0);
        chk("async_cout", {32'd0, cout}, 33'd0);
        @(negedge clk);
        reset = 1'b0;
        a = 32'd1;
        b = 32'd2;
        @(negedge clk);
        chk("after_async_y", {1'b0, y}, 33'd3);

        // Back-to-back random operands: each result lands one edge later.
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = $urandom;
            ref_sum(a, b, es, ec);
            qy.push_back(es);
            qc.push_back(ec);
            @(negedge clk);
            chk($sformatf("b2b%0d_y", i), {1'b0, y}, {1'b0, qy.pop_front()});
            chk($sformatf("b2b%0d_cout", i), {32'd0, cout}, {32'd0, qc.pop_front()});
        end

        // Wider random sweep, biased toward carry-heavy operands.
        for (int i = 0; i < 200; i++) begin
            a = (i % 4 == 0) ? ~word_t'($urandom_range(255)) : word_t'($urandom);
            b = (i % 4 == 1) ? word_t'($urandom_range(255))  : word_t'($urandom);
            ref_sum(a, b, es, ec);
            @(negedge clk);
            chk($sformatf("rnd%0d_y", i), {1'b0, y}, {1'b0, es});
            chk($sformatf("rnd%0d_cout", i), {32'd0, cout}, {32'd0, ec});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_adder_32
